mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
- Parametrised, multi-cycle multiply/divide unit for the RV32M extension; successor to the single-cycle combinational ALU.
- Sits beside the ALU in the EX stage and is selected when the decoder flags an M-extension op.
- Uses a radix-2 iterative datapath: one shift-add or shift-subtract step per cycle.
- Valid/ready handshakes on both sides, so the hazard unit can stall the pipeline while `busy` is high.

Parameters:
- XLEN, 32, operand/result width; legal values are even and ≥ 4.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- clk        input   1        rising-edge clock
- rst        input   1        synchronous, active-high reset
- in_valid   input   1        operation request
- in_ready   output  1        unit can accept; equals (state == IDLE)
- op         input   3        RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operand1   input   XLEN     rs1 value
- operand2   input   XLEN     rs2 value
- flush      input   1        abort the in-flight op (branch mispredict/exception)
- out_valid  output  1        result available
- out_ready  input   1        consumer accepts result
- result     output  XLEN     result, held stable while out_valid=1
- busy       output  1        (state != IDLE); drives the EX stall

Behaviour:
- FSM states: IDLE, CALC, DONE.
- Reset (rst=1 at a clock edge): state goes to IDLE; result, out_valid, the counter and all datapath registers clear to 0. Reset overrides every other input, including mid-operation.
- IDLE:
  - in_valid & in_ready: latch op/operands, compute sign flags, load |operands| where signed, counter=0, go to CALC.
- CALC: one iteration per cycle; after XLEN iterations go to DONE.
  - Accept at edge 0 gives out_valid=1 from edge XLEN+1.
  - Latency is fixed at XLEN+1 cycles regardless of operand values (unless the optional feature is compiled in).
- Multiply:
  - Unsigned shift-add over magnitudes produces a 2*XLEN-bit product, then conditionally negated.
  - Signedness by op: MUL low half; MULH signed×signed high; MULHSU signed×unsigned high; MULHU unsigned high.
- Divide:
  - Restoring division on magnitudes.
  - Quotient sign = sign1 ^ sign2; remainder sign = sign of the dividend (DIV/REM only).
- Special cases (RISC-V spec), resolved when entering DONE:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give operand1.
  - Signed overflow (operand1 = most-negative, operand2 = −1): DIV gives most-negative; REM gives 0.
- DONE:
  - out_valid=1 and result stable.
  - out_valid & out_ready: go to IDLE. A new request can be accepted no earlier than the following cycle (in_ready=0 in DONE).
- flush:
  - In CALC or DONE: go to IDLE next cycle; out_valid=0; the result is discarded.
  - In IDLE: blocks acceptance that cycle.
  - flush has priority over out_ready.
- Simultaneous events: rst > flush > handshake.
- in_valid while busy is ignored; the requester must hold its request.

Optional Feature:
- Macro `MDU_EARLY_OUT_EN`.
- Defined: in IDLE on accept, the following ops skip CALC and enter DONE directly (latency 1; out_valid at edge 1):
  - divide by zero;
  - signed overflow;
  - any multiply with a zero operand (result 0).
- Not defined: every op takes the full XLEN+1 cycles, and results are identical.

Test Plan (XLEN=32, out_ready=1 unless stated):
- MUL 0x00000007 × 0xFFFFFFFD → result 0xFFFFFFEB; out_valid exactly 33 cycles after accept; busy high throughout.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed division:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFFF/0x10 → 0x0FFFFFFF; REMU → 0x0000000F.
- Special cases:
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - Latency is 33 cycles without the macro and 1 cycle with `MDU_EARLY_OUT_EN`.
- Backpressure and re-request:
  - Hold out_ready=0 for 5 cycles in DONE: result stays stable, out_valid stays 1, in_ready stays 0.
  - Then out_ready=1: IDLE the next cycle; a second request is accepted after that.
- Flush and reset:
  - Assert flush at CALC iteration 10: IDLE next cycle, no out_valid pulse; the next op completes correctly.
  - Assert rst mid-CALC: all outputs return to 0 (in_ready then 1).

Source files
------------

// File: rtl/mdu_iterative.sv
// mdu_iterative: radix-2 iterative RV32M multiply/divide unit.
// Optional early-out for trivial operations: define MDU_EARLY_OUT_EN.
module mdu_iterative #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] m_q, m_d;        // multiplicand or divisor magnitude
  logic [XLEN-1:0] hi_q, hi_d;      // product high half or partial remainder
  logic [XLEN-1:0] lo_q, lo_d;      // multiplier/product low half or dividend/quotient
  logic [XLEN-1:0] result_q, result_d;
  logic            neg_q, neg_d;    // negate product / quotient
  logic            rneg_q, rneg_d;  // negate remainder
  logic            div0_q, div0_d;
  logic            ovf_q, ovf_d;

  // Request decode: signedness, magnitudes and RISC-V special cases
  logic            is_div_in, s1_in, s2_in, div0_in, ovf_in;
  logic [XLEN-1:0] mag1, mag2;

  always_comb begin
    is_div_in = op[2];
    if (is_div_in) begin
      s1_in = ~op[0] & operand1[XLEN-1];
      s2_in = ~op[0] & operand2[XLEN-1];
    end else begin
      s1_in = (op[1:0] == 2'b01 || op[1:0] == 2'b10) & operand1[XLEN-1];
      s2_in = (op[1:0] == 2'b01) & operand2[XLEN-1];
    end
    mag1    = s1_in ? -operand1 : operand1;
    mag2    = s2_in ? -operand2 : operand2;
    div0_in = is_div_in & (operand2 == '0);
    ovf_in  = is_div_in & ~op[0] & (operand1 == MIN_NEG) & (operand2 == '1);
  end

  // Single iteration of shift-add and restoring shift-subtract, plus final fixup
  logic [XLEN:0]     msum, dshift;
  logic              dge;
  logic [XLEN-1:0]   ddiff, quot, rem, mul_res, div_res;
  logic [2*XLEN-1:0] prod, prod_s;

  always_comb begin
    msum    = {1'b0, hi_q} + {1'b0, m_q & {XLEN{lo_q[0]}}};
    dshift  = {hi_q, lo_q[XLEN-1]};
    dge     = dshift >= {1'b0, m_q};
    ddiff   = dshift[XLEN-1:0] - m_q;
    prod    = {hi_q, lo_q};
    prod_s  = neg_q ? -prod : prod;
    mul_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    quot    = neg_q ? -lo_q : lo_q;
    rem     = rneg_q ? -hi_q : hi_q;
    if (op_q[1])
      div_res = ovf_q ? '0 : rem;
    else if (div0_q)
      div_res = '1;
    else if (ovf_q)
      div_res = MIN_NEG;
    else
      div_res = quot;
  end

`ifdef MDU_EARLY_OUT_EN
  logic            early_in;
  logic [XLEN-1:0] early_res;

  always_comb begin
    early_in = div0_in | ovf_in | (~is_div_in & ((operand1 == '0) | (operand2 == '0)));
    if (!is_div_in)
      early_res = '0;
    else if (op[1])
      early_res = div0_in ? operand1 : '0;
    else
      early_res = div0_in ? '1 : MIN_NEG;
  end
`endif

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d    = op;
          cnt_d   = '0;
          hi_d    = '0;
          m_d     = is_div_in ? mag2 : mag1;
          lo_d    = is_div_in ? mag1 : mag2;
          neg_d   = s1_in ^ s2_in;
          rneg_d  = is_div_in & s1_in;
          div0_d  = div0_in;
          ovf_d   = ovf_in;
          state_d = CALC;
`ifdef MDU_EARLY_OUT_EN
          if (early_in) begin
            result_d = early_res;
            state_d  = DONE;
          end
`endif
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(XLEN)) begin
          // one extra cycle after the last step resolves signs and special cases
          result_d = op_q[2] ? div_res : mul_res;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (op_q[2]) begin
            hi_d = dge ? ddiff : dshift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], dge};
          end else begin
            hi_d = msum[XLEN:1];
            lo_d = {msum[0], lo_q[XLEN-1:1]};
          end
        end
      end
      DONE: begin
        if (flush || out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed vectors against a behavioural RV32M model.
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  mdu_iterative #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .operand1(operand1), .operand2(operand2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // RISC-V M-extension semantics computed with wide native arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (o)
      3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bit trivial;
    trivial = o[2] ? (b == 0 || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))
                   : (a == 0 || b == 0);
    return (EARLY && trivial) ? 1 : 33;
  endfunction

  // Transaction-level model: accept, count down latency, hold result until taken
  logic        m_busy = 1'b0, m_ov = 1'b0, m_known = 1'b0, mon_en = 1'b0;
  int          m_left = 0;
  logic [31:0] m_exp = '0, m_res = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_ov <= 1'b0; m_left <= 0; m_res <= '0; m_known <= 1'b1;
    end else if (!m_busy) begin
      if (in_valid && !flush) begin
        m_busy  <= 1'b1;
        m_left  <= lat(op, operand1, operand2);
        m_exp   <= ref_res(op, operand1, operand2);
        m_known <= 1'b0;
      end
    end else if (flush) begin
      m_busy <= 1'b0; m_ov <= 1'b0;
    end else if (m_ov) begin
      if (out_ready) begin m_busy <= 1'b0; m_ov <= 1'b0; end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) begin m_ov <= 1'b1; m_res <= m_exp; end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready", {31'b0, in_ready}, {31'b0, !m_busy});
      check("busy", {31'b0, busy}, {31'b0, m_busy});
      check("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
      if (m_ov || m_known) check("result", result, m_res);
    end
  end

  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string nm);
    bit acc = 1'b0;
    op = o; operand1 = a; operand2 = b; in_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check({nm, "_accept"}, {31'b0, acc}, 32'd1);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lit, input string nm);
    bit seen = 1'b0;
    int k = 0;
    check({nm, "_model"}, ref_res(o, a, b), lit);
    start_op(o, a, b, nm);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1; else k++;
    end
    check({nm, "_latency"}, k, lat(o, a, b));
    check({nm, "_result"}, result, lit);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset_result", result, 32'h0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);

    do_op(3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, "MUL");
    do_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "MULH");
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "MULHU");
    do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "MULHSU");
    do_op(3'd0, 32'h00000000, 32'h00001234, 32'h00000000, "MUL_zero");
    do_op(3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, "DIV_neg");
    do_op(3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, "REM_neg");
    do_op(3'd5, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, "DIVU");
    do_op(3'd7, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, "REMU");
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "DIV_ovf");
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "REM_ovf");
    do_op(3'd4, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, "DIV_by0");
    do_op(3'd6, 32'h00000005, 32'h00000000, 32'h00000005, "REM_by0");
    do_op(3'd6, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, "REM_neg_by0");
    do_op(3'd5, 32'h00000009, 32'h00000000, 32'hFFFFFFFF, "DIVU_by0");

    // Backpressure: result held while consumer stalls
    out_ready = 1'b0;
    do_op(3'd0, 32'h00010001, 32'h00010001, 32'h00020001, "MUL_bp");
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_result", result, 32'h00020001);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_release_idle", {31'b0, in_ready}, 32'd1);
    do_op(3'd5, 32'd100, 32'd7, 32'd14, "DIVU_after_bp");

    // Flush in IDLE blocks acceptance
    op = 3'd0; operand1 = 32'd3; operand2 = 32'd4; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", {31'b0, busy}, 32'd0);

    // Flush mid-calculation
    start_op(3'd0, 32'd1000, 32'd1000, "MUL_flush");
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    do_op(3'd7, 32'd1000, 32'd33, 32'd10, "REMU_after_flush");

    // Reset mid-calculation
    start_op(3'd3, 32'hDEADBEEF, 32'h12345678, "MULHU_rst");
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'h0);
    @(posedge clk); #1;
    do_op(3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, "MULH_after_rst");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
